// File: rtl/mips_ctrl_multiciclo.sv
// mips_ctrl_multiciclo: multi-cycle MIPS control FSM with retired counter and trap handling
//  clk, rst              : clock, synchronous active-high reset
//  run                   : permit a new fetch (looked at only in FETCH)
//  opcode, funct         : fields of the current instruction, latched in DECODE
//  cero, mem_ack         : ALU zero flag, data-memory completion
//  EscrPC .. EscrMem     : datapath selects and write enables
//  mem_req               : data-memory request, held in MEM
//  trap, trap_code       : sticky error flag and cause (01 illegal, 10 memory timeout)
//  retired               : count of completed instructions
module mips_ctrl_multiciclo #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             cero,
    input  logic             mem_ack,
    output logic             EscrPC,
    output logic             RegDest,
    output logic             FuenteALU,
    output logic [2:0]       ALUOp,
    output logic             MemaReg,
    output logic             EscrReg,
    output logic             FuentePC,
    output logic             SaltoCond,
    output logic             SaltoIncond,
    output logic             LeerMem,
    output logic             EscrMem,
    output logic             mem_req,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [CNT_W-1:0] retired
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    state_t state, next;
    logic [5:0] op_q, fn_q;
    logic [CW-1:0] wait_cnt;
    logic legal, is_r, is_lw, is_sw, is_beq, is_j, is_addi, in_instr;
    logic [2:0] r_alu;

    always_comb begin
        legal = (opcode == OP_R && (funct == F_ADD || funct == F_SUB || funct == F_AND ||
                 funct == F_OR || funct == F_SLT)) || opcode == OP_LW || opcode == OP_SW ||
                opcode == OP_BEQ || opcode == OP_J || opcode == OP_ADDI;
        is_r    = op_q == OP_R;
        is_lw   = op_q == OP_LW;
        is_sw   = op_q == OP_SW;
        is_beq  = op_q == OP_BEQ;
        is_j    = op_q == OP_J;
        is_addi = op_q == OP_ADDI;
        r_alu   = fn_q == F_SUB ? 3'b001 : fn_q == F_AND ? 3'b010 :
                  fn_q == F_OR  ? 3'b011 : fn_q == F_SLT ? 3'b100 : 3'b000;
        // datapath selects stay valid from EXEC through write-back
        in_instr    = state == EXEC || state == MEM || state == WB;
        RegDest     = in_instr && is_r;
        FuenteALU   = in_instr && (is_lw || is_sw || is_addi);
        ALUOp       = !in_instr ? 3'b000 : is_beq ? 3'b001 : is_r ? r_alu : 3'b000;
        trap        = state == TRAP;
        next        = state;
        EscrPC      = 1'b0;
        MemaReg     = 1'b0;
        EscrReg     = 1'b0;
        FuentePC    = 1'b0;
        SaltoCond   = 1'b0;
        SaltoIncond = 1'b0;
        LeerMem     = 1'b0;
        EscrMem     = 1'b0;
        mem_req     = 1'b0;
        case (state)
            FETCH:  next = run ? DECODE : FETCH;
            DECODE: next = legal ? EXEC : TRAP;
            EXEC: begin
                SaltoCond   = is_beq;
                SaltoIncond = is_j;
                FuentePC    = is_beq && cero;
                EscrPC      = is_beq || is_j;
                next        = (is_beq || is_j) ? FETCH : (is_lw || is_sw) ? MEM : WB;
            end
            MEM: begin
                mem_req = 1'b1;
                LeerMem = is_lw;
                EscrMem = is_sw;
                EscrPC  = mem_ack && is_sw;
                next    = mem_ack ? (is_lw ? WB : FETCH) :
                          wait_cnt == CW'(MEM_TIMEOUT - 1) ? TRAP : MEM;
            end
            WB: begin
                EscrReg = 1'b1;
                MemaReg = is_lw;
                EscrPC  = 1'b1;
                next    = FETCH;
            end
            default: next = TRAP;
        endcase
        // a reset cycle must not commit anything, whatever state it interrupts
        if (rst) begin
            RegDest     = 1'b0;
            FuenteALU   = 1'b0;
            ALUOp       = 3'b000;
            EscrPC      = 1'b0;
            MemaReg     = 1'b0;
            EscrReg     = 1'b0;
            FuentePC    = 1'b0;
            SaltoCond   = 1'b0;
            SaltoIncond = 1'b0;
            LeerMem     = 1'b0;
            EscrMem     = 1'b0;
            mem_req     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            wait_cnt  <= '0;
            trap_code <= 2'b00;
            retired   <= '0;
        end else begin
            state    <= next;
            wait_cnt <= state == MEM ? wait_cnt + 1'b1 : '0;
            if (state == DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (EscrPC) retired <= retired + 1'b1;
            if (next == TRAP && state != TRAP) trap_code <= state == DECODE ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: tb/tb_mips_ctrl_multiciclo.sv
// tb_mips_ctrl_multiciclo: directed self-checking bench for the multi-cycle MIPS control FSM
module tb_mips_ctrl_multiciclo;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, cero = 1'b0, mem_ack = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic EscrPC, RegDest, FuenteALU, MemaReg, EscrReg, FuentePC, SaltoCond, SaltoIncond;
    logic LeerMem, EscrMem, mem_req, trap;
    logic [2:0] ALUOp;
    logic [1:0] trap_code;
    logic [31:0] retired;
    int errors = 0, checks = 0;
    logic [31:0] exp_ret = 0;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

    mips_ctrl_multiciclo #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct), .cero(cero),
        .mem_ack(mem_ack), .EscrPC(EscrPC), .RegDest(RegDest), .FuenteALU(FuenteALU),
        .ALUOp(ALUOp), .MemaReg(MemaReg), .EscrReg(EscrReg), .FuentePC(FuentePC),
        .SaltoCond(SaltoCond), .SaltoIncond(SaltoIncond), .LeerMem(LeerMem),
        .EscrMem(EscrMem), .mem_req(mem_req), .trap(trap), .trap_code(trap_code),
        .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        mem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_ret = 0;
    endtask

    // steps from FETCH (cycle 1) until EscrPC is seen; cyc=0 if it never appears
    task automatic wait_pc(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (EscrPC) begin
                cyc = i;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        do_reset();
        outs = {EscrPC, RegDest, FuenteALU, ALUOp, MemaReg, EscrReg, FuentePC, SaltoCond,
                SaltoIncond, LeerMem, EscrMem, mem_req};
        checks++;
        if (outs !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero", outs);
        end
        checks++;
        if ({trap, trap_code} !== 3'b000 || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: trap=%b code=%b retired=%0d expected 0/00/0", trap, trap_code, retired);
        end
    endtask

    task automatic test_add();
        int c;
        opcode = OP_R;
        funct = 6'b100000;
        run = 1'b1;
        wait_pc(c);
        run = 1'b0;
        checks++;
        if (c !== 4) begin
            errors++;
            $display("FAIL add_latency: got %0d expected 4", c);
        end
        checks++;
        if ({EscrReg, RegDest, ALUOp, MemaReg, FuenteALU} !== 7'b1100000) begin
            errors++;
            $display("FAIL add_wb: got %b expected 1100000", {EscrReg, RegDest, ALUOp, MemaReg, FuenteALU});
        end
        step();
        exp_ret++;
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL add_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_alu_decode();
        logic [5:0] fns [5];
        logic [2:0] alus [5];
        int c;
        fns = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        alus = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
        for (int k = 0; k < 5; k++) begin
            opcode = (k == 4) ? OP_ADDI : OP_R;
            funct = fns[k];
            run = 1'b1;
            wait_pc(c);
            run = 1'b0;
            checks++;
            if (c !== 4 || ALUOp !== alus[k] || RegDest !== (k != 4) || FuenteALU !== (k == 4) ||
                EscrReg !== 1'b1 || MemaReg !== 1'b0) begin
                errors++;
                $display("FAIL alu_decode_%0d: lat=%0d alu=%b rd=%b imm=%b wr=%b mr=%b expected lat=4 alu=%b rd=%b imm=%b wr=1 mr=0",
                         k, c, ALUOp, RegDest, FuenteALU, EscrReg, MemaReg, alus[k], k != 4, k == 4);
            end
            step();
            exp_ret++;
        end
    endtask

    task automatic test_latency();
        logic [5:0] ops [6];
        int lat [6];
        int c;
        ops = '{OP_R, OP_ADDI, OP_SW, OP_LW, OP_BEQ, OP_J};
        lat = '{4, 4, 4, 5, 3, 3};
        funct = 6'b100000;
        mem_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            opcode = ops[k];
            run = 1'b1;
            wait_pc(c);
            run = 1'b0;
            checks++;
            if (c !== lat[k]) begin
                errors++;
                $display("FAIL latency_op%h: got %0d expected %0d", ops[k], c, lat[k]);
            end
            step();
            exp_ret++;
        end
        mem_ack = 1'b0;
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL latency_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_lw_wait();
        int n = 0;
        opcode = OP_LW;
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        checks++;
        if (FuenteALU !== 1'b1 || ALUOp !== 3'b000 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL lw_exec: imm=%b alu=%b req=%b expected 1 000 0", FuenteALU, ALUOp, mem_req);
        end
        step();
        for (int k = 1; k <= 10; k++) begin
            if (!(mem_req && LeerMem && !EscrMem && !EscrPC)) break;
            n++;
            mem_ack = (k == 3);
            step();
        end
        mem_ack = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL lw_mem_cycles: got %0d expected 3", n);
        end
        checks++;
        if ({MemaReg, EscrReg, EscrPC, mem_req} !== 4'b1110) begin
            errors++;
            $display("FAIL lw_wb: got %b expected 1110", {MemaReg, EscrReg, EscrPC, mem_req});
        end
        step();
        exp_ret++;
        checks++;
        if (retired !== exp_ret || EscrPC !== 1'b0) begin
            errors++;
            $display("FAIL lw_retired: got %0d pc=%b expected %0d pc=0", retired, EscrPC, exp_ret);
        end
    endtask

    task automatic test_sw_ack();
        opcode = OP_SW;
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        mem_ack = 1'b1;
        #1;
        checks++;
        if ({mem_req, EscrMem, LeerMem, EscrReg, EscrPC} !== 5'b11001) begin
            errors++;
            $display("FAIL sw_mem: got %b expected 11001", {mem_req, EscrMem, LeerMem, EscrReg, EscrPC});
        end
        step();
        mem_ack = 1'b0;
        exp_ret++;
    endtask

    task automatic test_branch();
        int c;
        for (int k = 0; k < 3; k++) begin
            opcode = (k == 2) ? OP_J : OP_BEQ;
            cero = (k == 0);
            run = 1'b1;
            wait_pc(c);
            run = 1'b0;
            checks++;
            if (c !== 3 || FuentePC !== (k == 0) || SaltoCond !== (k != 2) || SaltoIncond !== (k == 2) ||
                ALUOp !== ((k == 2) ? 3'b000 : 3'b001) || EscrReg !== 1'b0) begin
                errors++;
                $display("FAIL branch_%0d: lat=%0d fpc=%b sc=%b si=%b alu=%b wr=%b expected lat=3 fpc=%b sc=%b si=%b",
                         k, c, FuentePC, SaltoCond, SaltoIncond, ALUOp, EscrReg, k == 0, k != 2, k == 2);
            end
            step();
            exp_ret++;
        end
        cero = 1'b0;
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL branch_retired: got %0d expected %0d", retired, exp_ret);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0, last = 0;
        opcode = OP_R;
        funct = 6'b100000;
        run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (EscrPC) begin
                pulses++;
                last = i;
            end
            step();
        end
        run = 1'b0;
        exp_ret += 2;
        checks++;
        if (pulses !== 2 || last !== 8 || retired !== exp_ret) begin
            errors++;
            $display("FAIL back_to_back: pulses=%0d last=%0d retired=%0d expected 2 8 %0d", pulses, last, retired, exp_ret);
        end
    endtask

    task automatic test_run_hold();
        logic any = 1'b0;
        opcode = OP_R;
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            any |= EscrPC | EscrReg | mem_req | RegDest | SaltoCond | trap;
            step();
        end
        mem_ack = 1'b0;
        checks++;
        if (any !== 1'b0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL run_hold: activity=%b retired=%0d expected 0 %0d", any, retired, exp_ret);
        end
    endtask

    task automatic test_rst_mid();
        int c;
        opcode = OP_LW;
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        step();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: mem_req=%b expected 1", mem_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, EscrPC, EscrReg} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_during: got %b expected 000", {mem_req, EscrPC, EscrReg});
        end
        step();
        rst = 1'b0;
        exp_ret = 0;
        checks++;
        if ({mem_req, LeerMem, trap} !== 3'b000 || retired !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_after: req/rd/trap=%b retired=%0d expected 000 0", {mem_req, LeerMem, trap}, retired);
        end
        opcode = OP_R;
        funct = 6'b100000;
        run = 1'b1;
        wait_pc(c);
        run = 1'b0;
        checks++;
        if (c !== 4) begin
            errors++;
            $display("FAIL rst_mid_restart: latency %0d expected 4", c);
        end
        step();
        exp_ret++;
    endtask

    task automatic test_illegal();
        int pcs = 0;
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 0) ? 6'b111111 : OP_R;
            funct = 6'b000001;
            run = 1'b1;
            step();
            step();
            checks++;
            if (trap !== 1'b1 || trap_code !== 2'b01) begin
                errors++;
                $display("FAIL illegal_%0d: trap=%b code=%b expected 1 01", k, trap, trap_code);
            end
            mem_ack = 1'b1;
            pcs = 0;
            for (int i = 0; i < 20; i++) begin
                pcs += int'(EscrPC) + int'(EscrReg) + int'(mem_req);
                step();
            end
            checks++;
            if (pcs !== 0 || retired !== exp_ret || trap !== 1'b1) begin
                errors++;
                $display("FAIL illegal_hold_%0d: activity=%0d retired=%0d trap=%b expected 0 %0d 1", k, pcs, retired, trap, exp_ret);
            end
            do_reset();
            checks++;
            if (trap !== 1'b0 || trap_code !== 2'b00 || retired !== 32'd0) begin
                errors++;
                $display("FAIL illegal_clear_%0d: trap=%b code=%b retired=%0d expected 0 00 0", k, trap, trap_code, retired);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        opcode = OP_SW;
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            n++;
            step();
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected 15", n);
        end
        checks++;
        if (trap !== 1'b1 || trap_code !== 2'b10 || EscrMem !== 1'b0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL timeout_trap: trap=%b code=%b escrmem=%b retired=%0d expected 1 10 0 %0d",
                     trap, trap_code, EscrMem, retired, exp_ret);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_decode();
        test_latency();
        test_lw_wait();
        test_sw_ack();
        test_branch();
        test_back_to_back();
        test_run_hold();
        test_rst_mid();
        test_illegal();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
